// File: rtl/mem_copy.sv
// Word-by-word copy engine driving a 2-port RAM with 1-cycle read latency.
// Reads stream from the source region; writes trail them by one cycle.
module mem_copy #(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8,
  parameter int NUM_WORDS = 2 ** ADDR_BITS
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic [ADDR_BITS-1:0] in_src_addr,
  input  logic [ADDR_BITS-1:0] in_dst_addr,
  input  logic [ADDR_BITS:0]   in_len,
  output logic                 out_busy,
  output logic                 out_done,
  output logic                 out_rd_ena,
  output logic [ADDR_BITS-1:0] out_rd_addr,
  input  logic [WORD_BITS-1:0] in_rd_data,
  output logic                 out_wr_ena,
  output logic [ADDR_BITS-1:0] out_wr_addr,
  output logic [WORD_BITS-1:0] out_wr_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_BITS:0]   MAX_LEN   = (ADDR_BITS+1)'(NUM_WORDS);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

  state_t               state;
  logic [ADDR_BITS:0]   cnt;
  logic [ADDR_BITS-1:0] dst_ptr;
  logic [ADDR_BITS-1:0] rd_addr_q;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic                 rd_ena_q;
  logic                 wr_ena_q;
  logic                 busy_q;
  logic                 done_q;
  logic [ADDR_BITS:0]   len_eff;

  function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Folds a start address into range when NUM_WORDS is not a power of two.
  function automatic logic [ADDR_BITS-1:0] fold_addr(input logic [ADDR_BITS-1:0] a);
    return ADDR_BITS'(32'(a) % NUM_WORDS);
  endfunction

  assign len_eff = (in_len > MAX_LEN) ? MAX_LEN : in_len;

  // cnt holds the number of reads still to issue after the current one.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dst_ptr   <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_ena_q  <= 1'b0;
      wr_ena_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            busy_q <= 1'b1;
            if (len_eff == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= READ;
              rd_ena_q  <= 1'b1;
              rd_addr_q <= fold_addr(in_src_addr);
              dst_ptr   <= fold_addr(in_dst_addr);
              cnt       <= len_eff - 1'b1;
            end
          end
        end
        READ: begin
          wr_ena_q  <= 1'b1;
          wr_addr_q <= dst_ptr;
          dst_ptr   <= next_addr(dst_ptr);
          if (cnt == '0) begin
            state     <= DRAIN;
            rd_ena_q  <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            rd_addr_q <= next_addr(rd_addr_q);
            cnt       <= cnt - 1'b1;
          end
        end
        DRAIN: begin
          wr_ena_q  <= 1'b0;
          wr_addr_q <= '0;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset masks the outputs immediately so an in-flight write never lands.
  assign out_busy    = busy_q & ~in_rst;
  assign out_done    = done_q & ~in_rst;
  assign out_rd_ena  = rd_ena_q & ~in_rst;
  assign out_wr_ena  = wr_ena_q & ~in_rst;
  assign out_rd_addr = in_rst ? '0 : rd_addr_q;
  assign out_wr_addr = in_rst ? '0 : wr_addr_q;
  assign out_wr_data = in_rd_data;

endmodule

// File: tb/tb_mem_copy.sv
// Bench for mem_copy: a behavioural RAM, a copy model predicting cycle timing,
// write data and final memory contents, and random plus directed copies.
module tb_mem_copy;

  localparam int AW = 3;
  localparam int WW = 8;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic          rd_ena;
  logic [AW-1:0] rd_addr;
  logic [WW-1:0] rd_data;
  logic          wr_ena;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;

  logic [WW-1:0] ram [NW];
  logic [WW-1:0] init_mem [NW];
  logic [WW-1:0] exp_mem [NW];
  logic          load;
  logic [WW-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  mem_copy #(.ADDR_BITS(AW), .WORD_BITS(WW), .NUM_WORDS(NW)) dut (
    .in_clk(clk), .in_rst(rst), .in_start(start),
    .in_src_addr(src_addr), .in_dst_addr(dst_addr), .in_len(len),
    .out_busy(busy), .out_done(done),
    .out_rd_ena(rd_ena), .out_rd_addr(rd_addr), .in_rd_data(rd_data),
    .out_wr_ena(wr_ena), .out_wr_addr(wr_addr), .out_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Two-port RAM, registered read, read-before-write on a shared address.
  always @(posedge clk) begin
    if (rd_ena) rd_data <= ram[rd_addr];
    if (load) ram <= init_mem;
    else if (wr_ena) ram[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_ram(input bit random_fill);
    start = 1'b0;
    for (int i = 0; i < NW; i++) init_mem[i] = random_fill ? WW'($urandom_range(0, 255)) : WW'(8'h10 + i);
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Ascending copy; read k sees writes 0..k-2 only (write k-1 lands on the same edge).
  task automatic model_copy(input int src, input int dst, input int len_in, output int le);
    logic [WW-1:0] m [NW];
    logic [WW-1:0] v [NW];
    le = (len_in > NW) ? NW : len_in;
    for (int i = 0; i < NW; i++) m[i] = ram[i];
    for (int k = 0; k < le; k++) begin
      if (k >= 2) m[(dst + k - 2) % NW] = v[k - 2];
      v[k] = m[(src + k) % NW];
    end
    for (int j = (le >= 2 ? le - 2 : 0); j < le; j++) m[(dst + j) % NW] = v[j];
    for (int k = 0; k < le; k++) exp_q.push_back(v[k]);
    exp_mem = m;
  endtask

  // Starts at the current negedge; returns at the negedge of the first idle cycle.
  task automatic run_copy(input int src, input int dst, input int len_in, input bit hold);
    int le;
    int total;
    bit exp_rd;
    bit exp_wr;
    model_copy(src, dst, len_in, le);
    total = (le == 0) ? 1 : le + 2;
    start = 1'b1;
    src_addr = AW'(src);
    dst_addr = AW'(dst);
    len = (AW+1)'(len_in);
    @(posedge clk);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = hold;
        src_addr = AW'($urandom_range(0, NW - 1));
        dst_addr = AW'($urandom_range(0, NW - 1));
        len = (AW+1)'($urandom_range(0, 15));
      end
      exp_rd = (c >= 1) && (c <= le);
      exp_wr = (c >= 2) && (c <= le + 1);
      check("rd_ena", rd_ena, exp_rd);
      check("rd_addr", rd_addr, exp_rd ? (src + c - 1) % NW : 0);
      check("wr_ena", wr_ena, exp_wr);
      check("wr_addr", wr_addr, exp_wr ? (dst + c - 2) % NW : 0);
      check("busy", busy, c <= total);
      check("done", done, c == total);
      if (exp_wr) begin
        if (exp_q.size() > 0) check("wr_data", wr_data, exp_q.pop_front());
        else check("wr_data_queue", 1, 0);
      end
    end
    check("exp_q_empty", exp_q.size(), 0);
    for (int i = 0; i < NW; i++) check("ram", ram[i], exp_mem[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_ena"}, rd_ena, 0);
    check({tag, "_wr_ena"}, wr_ena, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  // len=5 copy src=0 dst=4, reset in cycle 3: only the cycle-2 write survives.
  task automatic reset_mid_copy();
    load_ram(1'b0);
    for (int i = 0; i < NW; i++) exp_mem[i] = ram[i];
    exp_mem[4] = 8'h10;
    start = 1'b1;
    src_addr = 0;
    dst_addr = 4;
    len = 5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_c1_rd", rd_ena, 1);
    @(negedge clk);
    check("rst_mid_c2_wr", wr_ena, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid_c3");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid_c4");
    @(negedge clk);
    check_all_zero("rst_mid_c5");
    for (int i = 0; i < NW; i++) check("rst_mid_ram", ram[i], exp_mem[i]);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    start = 1'b1;
    @(negedge clk);
    check_all_zero("reset_start");
    start = 1'b0;
    rst = 1'b0;

    load_ram(1'b0);
    run_copy(0, 4, 3, 1'b0);
    load_ram(1'b0);
    run_copy(6, 1, 4, 1'b0);
    run_copy(2, 5, 0, 1'b0);
    load_ram(1'b1);
    run_copy(3, 0, 9, 1'b0);
    load_ram(1'b0);
    run_copy(1, 6, 3, 1'b1);
    run_copy(5, 0, 2, 1'b0);
    load_ram(1'b0);
    run_copy(0, 1, 3, 1'b0);
    reset_mid_copy();
    run_copy(2, 3, 4, 1'b0);

    load_ram(1'b1);
    for (int n = 0; n < 16; n++) begin
      run_copy($urandom_range(0, NW - 1), $urandom_range(0, NW - 1),
               $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("final_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
